// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: received byte, handshake and
// status pulses. The receiver uses the master modport; the consumer uses the slave one.
interface uart_rx_if;
    logic [7:0] uart_dat_o;
    logic       uart_valid_o;
    logic       uart_busy_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;
    logic       uart_rd_i;

    modport master (
        output uart_dat_o, uart_valid_o, uart_busy_o,
        output frame_err_o, overrun_o, parity_err_o,
        input  uart_rd_i
    );

    modport slave (
        input  uart_dat_o, uart_valid_o, uart_busy_o,
        input  frame_err_o, overrun_o, parity_err_o,
        output uart_rd_i
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with a 16x oversampling fractional tick generator and a
// single-entry holding register for the received byte.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after the eighth data bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge
// S_START  | start bit seen, confirm at its centre (8th tick)
// S_DATA   | sampling 8 data bits at bit centres, LSB first
// S_PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
// S_STOP   | sampling the stop bit; high commits the byte
// S_BREAK  | stop bit was low, wait for the line to return high
module uart_rx #(
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned SYS_CLK_RATE = 50000000
) (
    input  logic      sys_clk_i,
    input  logic      sys_rst_i,
    input  logic      uart_rx_i,
    uart_rx_if.master bus
);
    localparam logic [31:0] TICK_INC = 32'(16 * BAUD_RATE);
    localparam logic [31:0] TICK_MOD = 32'(SYS_CLK_RATE);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [31:0] r_acc;
    logic [31:0] w_acc_sum;
    logic        r_tick;
    logic [3:0]  r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_mid;
    logic        w_end;
    logic        w_shift;
    logic        w_commit;
    logic        w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic        w_par_chk;
`endif

    assign w_acc_sum = r_acc + TICK_INC;
    assign w_mid     = r_tick && (r_cnt == 4'd7);
    assign w_end     = r_tick && (r_cnt == 4'd15);

    // Two-flop synchronizer for the asynchronous serial line, idles high.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Fractional accumulator producing one tick per 1/16 bit period.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else if (w_acc_sum >= TICK_MOD) begin
            r_acc  <= w_acc_sum - TICK_MOD;
            r_tick <= 1'b1;
        end else begin
            r_acc  <= w_acc_sum;
            r_tick <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state decode and single-cycle datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_chk   = 1'b0;
`endif
        case (r_state)
            S_IDLE:  if (!r_rx_sync) w_state_nxt = S_START;
            S_START: if (w_mid) w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_end) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_end) begin
                    w_par_chk   = 1'b1;
                    w_state_nxt = S_STOP;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_STOP: begin
                if (w_end) begin
                    if (r_rx_sync) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: if (r_rx_sync) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tick counter restarts on every state change; bit index and shifter.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (r_tick)            r_cnt <= r_cnt + 4'd1;
            if (r_state == S_START)     r_bit_idx <= '0;
            else if (w_shift)           r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift)                r_shift <= {r_rx_sync, r_shift[7:1]};
        end
    end

    // Holding register: a commit wins over a same-cycle read.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            bus.uart_dat_o   <= 8'h00;
            bus.uart_valid_o <= 1'b0;
            bus.frame_err_o  <= 1'b0;
            bus.overrun_o    <= 1'b0;
        end else begin
            bus.frame_err_o <= w_frame_err;
            bus.overrun_o   <= 1'b0;
            if (w_commit) begin
                bus.uart_dat_o   <= r_shift;
                bus.uart_valid_o <= 1'b1;
                bus.overrun_o    <= bus.uart_valid_o && !bus.uart_rd_i;
            end else if (bus.uart_rd_i && bus.uart_valid_o) begin
                bus.uart_valid_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must hold an even number of ones.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) bus.parity_err_o <= 1'b0;
        else           bus.parity_err_o <= w_par_chk && ((^r_shift) ^ r_rx_sync);
    end
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.uart_busy_o = (r_state != S_IDLE);
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-002 Parameter SYS_CLK_RATE, default 50000000, sys_clk_i frequency in Hz.
REQ-003 Port sys_clk_i  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port sys_rst_i  input  1  system reset, asynchronous, active-high.
REQ-005 Port uart_rx_i  input  1  serial receive line, asynchronous to sys_clk_i, idle high.
REQ-006 Port uart_rd_i  input  1  consumer acknowledge; high for one cycle pops the held byte.
REQ-007 Port uart_dat_o  output  8  last received byte.
REQ-008 Port uart_valid_o  output  1  high while uart_dat_o holds an unacknowledged byte.
REQ-009 Port uart_busy_o  output  1  high while a frame is being received (state not IDLE).
REQ-010 Port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 Port overrun_o  output  1  one-cycle pulse: new byte completed while uart_valid_o high and uart_rd_i low.
REQ-012 Port parity_err_o  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-013 uart_rx_i SHALL pass through a 2-flop synchronizer (reset to 1) before any use.
REQ-014 Tick generator: 32-bit accumulator adds 16*BAUD_RATE each cycle; when sum >= SYS_CLK_RATE, subtract SYS_CLK_RATE and assert tick (16x oversample) for one cycle.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK; 4-bit tick counter, 3-bit bit index.
REQ-016 IDLE -> START on synchronized line low; tick counter cleared.
REQ-017 START: at 8th tick, line low -> DATA (counter cleared); line high -> IDLE (false start, no output).
REQ-018 DATA: sample at every 16th tick (bit centre), shift in LSB first; after bit 7 -> PARITY if enabled, else STOP.
REQ-019 STOP: sample at 16th tick; high -> byte commit, IDLE; low -> frame_err_o pulse, byte discarded, BREAK.
REQ-020 BREAK: remain until synchronized line high, then IDLE.
REQ-021 Commit: uart_dat_o <= byte, uart_valid_o <= 1 in the same cycle as the stop sample.
REQ-022 uart_rd_i with uart_valid_o high clears uart_valid_o next cycle; uart_rd_i with uart_valid_o low is ignored.
REQ-023 Commit and uart_rd_i same cycle: new byte loaded, uart_valid_o stays 1, no overrun.
REQ-024 Commit while uart_valid_o high, no uart_rd_i: new byte overwrites, overrun_o pulses.
REQ-025 Latency: uart_valid_o rises <= 1 tick period after stop-bit centre.

Reset
REQ-026 sys_rst_i high SHALL immediately force: state IDLE, accumulator/counters 0, synchronizer 1, uart_dat_o 8'h00, uart_valid_o/uart_busy_o/frame_err_o/overrun_o/parity_err_o 0.
REQ-027 Reset mid-frame SHALL abandon the frame; no error or valid pulse follows release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after bit 7; mismatch pulses parity_err_o, byte still committed.
REQ-029 Macro undefined: PARITY state unreachable, frame is 1+8+1 bits, parity_err_o tied 0.

Verification
REQ-030 Frame 0xA5 at 9600 baud, 50 MHz -> uart_dat_o=0xA5, uart_valid_o=1 until uart_rd_i, no error pulses.
REQ-031 Low glitch of 3 ticks on idle line -> returns to IDLE, uart_valid_o stays 0, uart_busy_o drops within 9 ticks.
REQ-032 Frame 0x3C with stop bit 0, line held low 2 bit times -> one frame_err_o pulse, uart_valid_o 0, IDLE only after line high.
REQ-033 Bytes 0x11 then 0x22 back-to-back, no uart_rd_i -> one overrun_o pulse, uart_dat_o=0x22; repeat with uart_rd_i on commit cycle -> no overrun.
REQ-034 sys_rst_i asserted during bit 4 of 0x5A, released, then 0x96 sent -> only 0x96 delivered, no error pulses.
REQ-035 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err_o pulse, uart_dat_o=0x07; parity bit 1 -> no pulse.
